// File: rtl/offset_buffer_array.sv
// offset_buffer_array: per-lane offset/operand register file for the NBin/offset
// datapath. Each of Tn lanes holds NUM_WORDS x N words with per-entry valid bits,
// an occupancy count, a streaming write pointer and a registered read port with
// read-valid and miss flags. Lanes share only rst, i_clear and i_wr_mode.
module offset_buffer_array #(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int ADDR      = 6,
  parameter int NUM_WORDS = 64,
  parameter int BYPASS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_wr_mode,
  input  logic [Tn-1:0]          i_wen,
  input  logic [Tn*ADDR-1:0]     i_wr_addr,
  input  logic [Tn*N-1:0]        i_data,
  input  logic [Tn-1:0]          i_ren,
  input  logic [Tn*ADDR-1:0]     i_rd_addr,
  output logic [Tn*N-1:0]        o_data,
  output logic [Tn-1:0]          o_rvalid,
  output logic [Tn-1:0]          o_miss,
  output logic [Tn-1:0]          o_full,
  output logic [Tn*(ADDR+1)-1:0] o_count
);

  // Depth expressed at pointer width so pointer/address compares stay width-matched.
  localparam logic [ADDR:0] DEPTH = NUM_WORDS[ADDR:0];

  // An address (zero-extended to pointer width) is usable only below the depth;
  // this also covers NUM_WORDS smaller than 2^ADDR.
  function automatic logic in_range(input logic [ADDR:0] a);
    return a < DEPTH;
  endfunction

  genvar g;
  for (g = 0; g < Tn; g++) begin : g_lane
    logic [N-1:0]         mem [NUM_WORDS];
    logic [NUM_WORDS-1:0] vld;
    logic [ADDR:0]        wr_ptr;
    logic [ADDR:0]        count;

    logic [N-1:0]         wdata_p0;
    logic [ADDR:0]        wa_p0;
    logic [ADDR-1:0]      wa_idx_p0;
    logic                 wr_ok_p0;
    logic                 wr_new_p0;
    logic [ADDR-1:0]      ra_p0;
    logic                 rd_in_p0;
    logic                 byp_p0;

    logic [N-1:0]         rdata_p1;
    logic                 vld_p1;
    logic                 miss_p1;

    // ---- stage p0: decode write target, write acceptance and read bypass ----
    // Streaming mode ignores the supplied address and uses the lane pointer; a
    // pointer sitting at the depth fails the range check, so the write drops.
    always_comb begin
      wdata_p0  = i_data[g*N +: N];
      ra_p0     = i_rd_addr[g*ADDR +: ADDR];
      wa_p0     = i_wr_mode ? wr_ptr : {1'b0, i_wr_addr[g*ADDR +: ADDR]};
      wa_idx_p0 = wa_p0[ADDR-1:0];
      wr_ok_p0  = i_wen[g] && !i_clear && !rst && in_range(wa_p0);
      wr_new_p0 = wr_ok_p0 && !vld[wa_idx_p0];
      rd_in_p0  = in_range({1'b0, ra_p0});
      // Clear and reset already squash wr_ok_p0, which also suppresses bypass.
      byp_p0    = (BYPASS != 0) && wr_ok_p0 && (wa_p0 == {1'b0, ra_p0});
    end

    // Valid bits, streaming pointer and occupancy; clear wins over writes.
    always_ff @(posedge clk) begin
      if (rst || i_clear) begin
        vld    <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok_p0) vld[wa_idx_p0] <= 1'b1;
        if (wr_new_p0) count <= count + 1'b1;
        if (wr_ok_p0 && i_wr_mode) wr_ptr <= wr_ptr + 1'b1;
      end
    end

    // Storage array; data is never reset, validity is tracked separately.
    always_ff @(posedge clk) begin
      if (wr_ok_p0) mem[wa_idx_p0] <= wdata_p0;
    end

    // ---- stage p1: registered read port ----
    // Reads see pre-edge state; a same-entry write is forwarded only when bypass
    // is enabled. Without a read the data register holds its last value.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
        miss_p1  <= 1'b0;
      end else begin
        vld_p1  <= i_ren[g];
        miss_p1 <= 1'b0;
        if (i_ren[g]) begin
          if (byp_p0) begin
            rdata_p1 <= wdata_p0;
          end else if (rd_in_p0 && vld[ra_p0]) begin
            rdata_p1 <= mem[ra_p0];
          end else begin
            rdata_p1 <= '0;
            miss_p1  <= 1'b1;
          end
        end
      end
    end

    assign o_data[g*N +: N]              = rdata_p1;
    assign o_rvalid[g]                   = vld_p1;
    assign o_miss[g]                     = miss_p1;
    assign o_full[g]                     = (wr_ptr == DEPTH);
    assign o_count[g*(ADDR+1) +: ADDR+1] = count;
  end

endmodule

// File: tb/tb_offset_buffer_array.sv
// Directed bench for offset_buffer_array: three builds (default, no-bypass,
// 48-entry) share one stimulus stream; expected values are hand-computed.
module tb_offset_buffer_array;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int AW = 6;
  localparam int CW = AW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_clear;
  logic            i_wr_mode;
  logic [TN-1:0]   i_wen;
  logic [TN*AW-1:0] i_wr_addr;
  logic [TN*N-1:0] i_data;
  logic [TN-1:0]   i_ren;
  logic [TN*AW-1:0] i_rd_addr;

  logic [TN*N-1:0]  a_data, b_data, c_data;
  logic [TN-1:0]    a_rvalid, b_rvalid, c_rvalid;
  logic [TN-1:0]    a_miss, b_miss, c_miss;
  logic [TN-1:0]    a_full, b_full, c_full;
  logic [TN*CW-1:0] a_count, b_count, c_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  offset_buffer_array #(.N(N), .Tn(TN), .ADDR(AW), .NUM_WORDS(64), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_wr_mode(i_wr_mode), .i_wen(i_wen),
    .i_wr_addr(i_wr_addr), .i_data(i_data), .i_ren(i_ren), .i_rd_addr(i_rd_addr),
    .o_data(a_data), .o_rvalid(a_rvalid), .o_miss(a_miss), .o_full(a_full), .o_count(a_count));

  offset_buffer_array #(.N(N), .Tn(TN), .ADDR(AW), .NUM_WORDS(64), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_wr_mode(i_wr_mode), .i_wen(i_wen),
    .i_wr_addr(i_wr_addr), .i_data(i_data), .i_ren(i_ren), .i_rd_addr(i_rd_addr),
    .o_data(b_data), .o_rvalid(b_rvalid), .o_miss(b_miss), .o_full(b_full), .o_count(b_count));

  offset_buffer_array #(.N(N), .Tn(TN), .ADDR(AW), .NUM_WORDS(48), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_wr_mode(i_wr_mode), .i_wen(i_wen),
    .i_wr_addr(i_wr_addr), .i_data(i_data), .i_ren(i_ren), .i_rd_addr(i_rd_addr),
    .o_data(c_data), .o_rvalid(c_rvalid), .o_miss(c_miss), .o_full(c_full), .o_count(c_count));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] dat(input logic [TN*N-1:0] v, input int l);
    return v[l*N +: N];
  endfunction

  function automatic logic [CW-1:0] cnt(input logic [TN*CW-1:0] v, input int l);
    return v[l*CW +: CW];
  endfunction

  task automatic idle();
    i_clear   = 1'b0;
    i_wen     = '0;
    i_ren     = '0;
    i_wr_addr = '0;
    i_rd_addr = '0;
    i_data    = '0;
  endtask

  task automatic wr(input int lane, input int addr, input logic [N-1:0] d);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    i_wen[lane]               = 1'b1;
    i_wr_addr[lane*AW +: AW]  = a;
    i_data[lane*N +: N]       = d;
  endtask

  task automatic rd(input int lane, input int addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    i_ren[lane]               = 1'b1;
    i_rd_addr[lane*AW +: AW]  = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_wr_mode = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_miss",   a_miss,   0);
    chk("rst_data",   a_data,   0);
    chk("rst_count",  a_count,  0);
    chk("rst_full",   a_full,   0);

    rst = 1'b0;
    rd(0, 5);
    tick(); idle();
    chk("cold_rvalid", a_rvalid, 16'h0001);
    chk("cold_miss",   a_miss,   16'h0001);
    chk("cold_data0",  dat(a_data, 0), 0);

    // addressed write and read on lane 3
    wr(3, 10, 16'hBEEF);
    tick(); idle();
    chk("aw_count", cnt(a_count, 3), 1);
    rd(3, 10);
    tick(); idle();
    chk("aw_data",   dat(a_data, 3), 16'hBEEF);
    chk("aw_miss",   a_miss, 0);
    chk("aw_rvalid", a_rvalid, 16'h0008);
    wr(3, 10, 16'h1234);
    tick(); idle();
    chk("rewrite_count", cnt(a_count, 3), 1);
    chk("hold_data",     dat(a_data, 3), 16'hBEEF);
    chk("hold_rvalid",   a_rvalid, 0);

    // one streaming write on lane 3 lands at entry 0: addressed writes left the pointer alone
    i_wr_mode = 1'b1;
    wr(3, 33, 16'h5A5A);
    tick(); idle();
    i_wr_mode = 1'b0;
    rd(3, 0);
    tick(); idle();
    chk("stream_first", dat(a_data, 3), 16'h5A5A);
    chk("stream_count", cnt(a_count, 3), 2);
    rd(3, 10);
    tick(); idle();
    chk("rewrite_data", dat(a_data, 3), 16'h1234);

    // streaming fill of lane 7
    i_wr_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin
      wr(7, 0, 16'(k));
      tick(); idle();
    end
    chk("fill_full",  a_full, 16'h0080);
    chk("fill_count", cnt(a_count, 7), 64);
    wr(7, 0, 16'hFFFF);
    tick(); idle();
    chk("drop65_count", cnt(a_count, 7), 64);
    chk("drop65_full",  a_full, 16'h0080);
    i_wr_mode = 1'b0;
    rd(7, 0);
    tick(); idle();
    chk("fill_rd0", dat(a_data, 7), 16'h0000);
    rd(7, 63);
    tick(); idle();
    chk("fill_rd63", dat(a_data, 7), 16'h003F);

    // same-cycle read/write on lane 1 addr 2
    wr(1, 2, 16'h1111);
    tick(); idle();
    wr(1, 2, 16'h2222);
    rd(1, 2);
    tick(); idle();
    chk("byp1_data", dat(a_data, 1), 16'h2222);
    chk("byp1_miss", a_miss, 0);
    chk("byp0_data", dat(b_data, 1), 16'h1111);
    chk("byp0_miss", b_miss, 0);

    // clear priority on lane 1 addr 4
    wr(1, 4, 16'h4444);
    tick(); idle();
    i_clear = 1'b1;
    wr(1, 4, 16'h9999);
    rd(1, 4);
    tick(); idle();
    chk("clr_rd_data",  dat(a_data, 1), 16'h4444);
    chk("clr_rd_miss",  a_miss, 0);
    chk("clr_rd_vld",   a_rvalid, 16'h0002);
    chk("clr_count",    a_count, 0);
    chk("clr_full",     a_full, 0);
    rd(1, 4);
    tick(); idle();
    chk("clr_after_miss", a_miss, 16'h0002);
    chk("clr_after_data", dat(a_data, 1), 0);

    // out-of-range on the 48-entry build
    wr(0, 50, 16'h7777);
    tick(); idle();
    chk("oor_count_c", cnt(c_count, 0), 0);
    chk("oor_count_a", cnt(a_count, 0), 1);
    rd(0, 50);
    tick(); idle();
    chk("oor_miss_c", c_miss, 16'h0001);
    chk("oor_data_c", dat(c_data, 0), 0);
    chk("oor_vld_c",  c_rvalid, 16'h0001);
    chk("oor_data_a", dat(a_data, 0), 16'h7777);
    wr(0, 47, 16'h4747);
    tick(); idle();
    chk("edge_count_c", cnt(c_count, 0), 1);
    rd(0, 47);
    tick(); idle();
    chk("edge_data_c", dat(c_data, 0), 16'h4747);

    // streaming fill of lane 2 reaches full at 48 only on the small build
    i_wr_mode = 1'b1;
    for (int k = 0; k < 48; k++) begin
      wr(2, 0, 16'h0100 + 16'(k));
      tick(); idle();
    end
    chk("fill48_full_c",  c_full, 16'h0004);
    chk("fill48_count_c", cnt(c_count, 2), 48);
    chk("fill48_full_a",  a_full, 0);
    wr(2, 0, 16'hAAAA);
    tick(); idle();
    chk("fill49_count_c", cnt(c_count, 2), 48);
    chk("fill49_count_a", cnt(a_count, 2), 49);
    i_wr_mode = 1'b0;
    rd(2, 47);
    tick(); idle();
    chk("fill48_rd47_c", dat(c_data, 2), 16'h012F);

    // reset mid-stream discards the cycle's traffic and invalidates everything
    rst = 1'b1;
    wr(5, 1, 16'h5555);
    rd(0, 47);
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_count",  a_count, 0);
    chk("mrst_rvalid", a_rvalid, 0);
    chk("mrst_data",   a_data, 0);
    rd(5, 1);
    tick(); idle();
    chk("mrst_miss", a_miss, 16'h0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
